// File: rtl/field_unpack_stream.sv
// field_unpack_stream: splits one IN-bit word per handshake into OUT-bit fields, LSB field first
//
// Ports:
//   clock     sole clock, rising edge
//   reset     synchronous, active-high
//   inValid   upstream word valid
//   inReady   block accepts a word this cycle
//   inData    word to split
//   inCount   fields to emit (0 or > FIELDS means FIELDS)
//   outValid  outData holds a valid field
//   outReady  downstream accepts the field this cycle
//   outData   current field, inData[k*OUT +: OUT]
//   outIndex  index k of the current field
//   outLast   current field is the final one of its word
module field_unpack_stream #(
    parameter  int IN     = 8,
    parameter  int OUT    = 8,
    localparam int FIELDS = IN / OUT,
    localparam int CW     = $clog2(FIELDS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inValid,
    output logic          inReady,
    input  logic [IN-1:0] inData,
    input  logic [CW-1:0] inCount,
    output logic          outValid,
    input  logic          outReady,
    output logic [OUT-1:0] outData,
    output logic [CW-1:0] outIndex,
    output logic          outLast
);

    if (OUT < 1 || OUT > IN || (IN % OUT) != 0) begin : g_bad_params
        $error("field_unpack_stream: IN must be a non-zero multiple of OUT");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    // Field table padded to a power of two so idx_q indexes it at full width.
    localparam int NF = 1 << CW;

    state_t          state_q;
    logic [IN-1:0]   buf_q;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [OUT-1:0]  field [NF];
    logic            accept;
    logic            fire;

    for (genvar i = 0; i < NF; i++) begin : g_field
        if (i < FIELDS) begin : g_used
            assign field[i] = buf_q[i*OUT +: OUT];
        end else begin : g_pad
            assign field[i] = '0;
        end
    end

    always_comb begin
        cnt_d = (inCount == '0 || inCount > CW'(FIELDS)) ? CW'(FIELDS) : inCount;
    end

    assign outValid = (state_q == EMIT);
    assign outData  = field[idx_q];
    assign outIndex = idx_q;
    // Gated by EMIT so a drained buffer never reports a stale last flag.
    assign outLast  = outValid && (idx_q == cnt_q - CW'(1));
    assign fire     = outValid && outReady;
    // Ready while empty, or when the final field leaves this very cycle.
    assign inReady  = (state_q == IDLE) || (fire && outLast);
    assign accept   = inValid && inReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= EMIT;
            buf_q   <= inData;
            idx_q   <= '0;
            cnt_q   <= cnt_d;
        end else if (fire) begin
            if (outLast) state_q <= IDLE;
            else idx_q <= idx_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_field_unpack_stream.sv
// tb_field_unpack_stream: scoreboard bench for field_unpack_stream (32/8 and 8/8 configurations)
module tb_field_unpack_stream;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_count = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [7:0]  out_data;
    logic [2:0]  out_index;
    logic        out_last;

    logic        v8 = 0;
    logic        r8;
    logic [7:0]  dat8 = '0;
    logic [0:0]  cnt8 = '0;
    logic        ov8;
    logic        or8 = 1;
    logic [7:0]  od8;
    logic [0:0]  oi8;
    logic        ol8;

    field_unpack_stream #(.IN(32), .OUT(8)) dut (
        .clock(clk), .reset(rst), .inValid(in_valid), .inReady(in_ready),
        .inData(in_data), .inCount(in_count), .outValid(out_valid),
        .outReady(out_ready), .outData(out_data), .outIndex(out_index),
        .outLast(out_last)
    );

    field_unpack_stream #(.IN(8), .OUT(8)) dut8 (
        .clock(clk), .reset(rst), .inValid(v8), .inReady(r8),
        .inData(dat8), .inCount(cnt8), .outValid(ov8),
        .outReady(or8), .outData(od8), .outIndex(oi8), .outLast(ol8)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] k;
        logic       l;
    } fld_t;

    fld_t       exp_q[$];
    logic [7:0] obs_q[$];
    int         cyc_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic void push_word(input logic [31:0] d, input logic [2:0] c);
        int n;
        n = (c == 0 || c > 4) ? 4 : int'(c);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{d: d[k*8 +: 8], k: 3'(k), l: (k == n - 1)});
    endfunction

    always @(negedge clk) begin
        fld_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected field: got %0h, expected none", out_data);
                end
            end else begin
                e = exp_q[0];
                chk("in_ready while emitting", 32'(in_ready), 32'(out_ready && e.l));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    chk("field data", 32'(out_data), 32'(e.d));
                    chk("field index", 32'(out_index), 32'(e.k));
                    chk("field last", 32'(out_last), 32'(e.l));
                    obs_q.push_back(out_data);
                    cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] c);
        logic acc;
        acc = 0;
        in_valid = 1;
        in_data  = d;
        in_count = c;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) push_word(d, c);
        else begin
            checks++;
            errors++;
            $display("FAIL send timeout: got in_ready 0, expected 1 within 200 cycles");
        end
        #1 in_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input logic [39:0] w, input int n);
        chk(name, 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++)
            chk(name, 32'(obs_q[i]), 32'(w[i*8 +: 8]));
    endtask

    task automatic clear_obs();
        obs_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        logic acc;
        int   sent;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_index", 32'(out_index), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset ov8", 32'(ov8), 32'd0);
        chk("reset r8", 32'(r8), 32'd1);
        @(posedge clk);
        #1;

        // Four fields, count 0 means all
        out_ready = 1;
        clear_obs();
        send(32'hDDCCBBAA, 3'd0);
        drain();
        check_obs("four fields", 40'h00DDCCBBAA, 4);
        if (cyc_q.size() == 4) chk("four fields contiguous", 32'(cyc_q[3] - cyc_q[0]), 32'd3);

        // Back-to-back words, no bubble
        clear_obs();
        send(32'h04030201, 3'd2);
        send(32'h08070605, 3'd3);
        drain();
        check_obs("back to back", 40'h0706050201, 5);
        if (cyc_q.size() == 5) chk("back to back contiguous", 32'(cyc_q[4] - cyc_q[0]), 32'd4);

        // Backpressure while 0xBB is presented
        clear_obs();
        out_ready = 0;
        send(32'hDDCCBBAA, 3'd0);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stall valid", 32'(out_valid), 32'd1);
            chk("stall data", 32'(out_data), 32'hBB);
            chk("stall index", 32'(out_index), 32'd1);
            chk("stall last", 32'(out_last), 32'd0);
            chk("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1;
        drain();
        check_obs("after stall", 40'h00DDCCBBAA, 4);

        // Reset mid-word, with a handshake offered during reset
        out_ready = 1;
        send(32'h44332211, 3'd0);
        @(posedge clk);
        #1 out_ready = 0;
        rst = 1;
        in_valid = 1;
        in_data = 32'hCAFEF00D;
        in_count = 3'd0;
        @(negedge clk);
        chk("pre-reset index", 32'(out_index), 32'd1);
        @(posedge clk);
        #1 rst = 0;
        in_valid = 0;
        exp_q.delete();
        @(negedge clk);
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1;
        clear_obs();
        send(32'h99887766, 3'd0);
        drain();
        check_obs("after reset", 40'h0099887766, 4);

        // Boundary counts
        clear_obs();
        send(32'hA1B2C3D4, 3'd1);
        send(32'h0F0E0D0C, 3'd7);
        drain();
        check_obs("count 1 then clamp 7", 40'h0F0E0D0CD4, 5);

        // Single-field configuration is a one-deep pipeline
        v8 = 1;
        dat8 = 8'h5A;
        cnt8 = 1'b0;
        @(negedge clk);
        chk("w8 ready", 32'(r8), 32'd1);
        chk("w8 no same-cycle out", 32'(ov8), 32'd0);
        @(posedge clk);
        #1 v8 = 0;
        @(negedge clk);
        chk("w8 valid", 32'(ov8), 32'd1);
        chk("w8 data", 32'(od8), 32'h5A);
        chk("w8 index", 32'(oi8), 32'd0);
        chk("w8 last", 32'(ol8), 32'd1);
        @(negedge clk);
        chk("w8 drained", 32'(ov8), 32'd0);
        @(posedge clk);
        #1;

        // Random handshakes on both sides
        sent = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) push_word(in_data, in_count);
            #1;
            if (acc) in_valid = 0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 60 && $urandom_range(0, 2) != 0) begin
                in_data  = $urandom;
                in_count = 3'($urandom_range(0, 7));
                in_valid = 1;
                sent++;
            end
        end
        in_valid = 0;
        out_ready = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/field_unpack_stream.md
# field_unpack_stream

Streaming width splitter upstream of field extraction: accepts one IN-bit word per valid/ready handshake and emits its OUT-bit fields one per cycle, least-significant field first. Field k is in[k*OUT +: OUT]; field 0 is bit-identical to the low-OUT-bit field extraction used elsewhere in the datapath, so single-field words pass through unchanged. One word of buffering gives full throughput with back-to-back words and no bubble between the last field of one word and the first field of the next.

## Interface
- IN, 8: input word width; must be a multiple of OUT (elaboration-time assertion)
- OUT, 8: field width; OUT <= IN (elaboration-time assertion)
- FIELDS, derived, IN/OUT: number of fields per word
- CW, derived, $clog2(FIELDS+1): width of count port

- clock  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- inValid  input  1  upstream word valid
- inReady  output  1  block can accept a word this cycle
- inData  input  IN  word to split
- inCount  input  CW  number of fields to emit, 1..FIELDS; 0 means FIELDS; values > FIELDS are clamped to FIELDS
- outValid  output  1  outData holds a valid field
- outReady  input  1  downstream accepts field this cycle
- outData  output  OUT  current field
- outIndex  output  CW  index k of current field
- outLast  output  1  current field is the final one of its word

## Operation
- States: IDLE (buffer empty), EMIT (buffer holds a word, fields remaining).
- Registers: word buffer (IN), field index idx (CW), effective count cnt (CW).
- Input accept occurs when inValid && inReady. inReady = (state == IDLE) || (outValid && outReady && outLast). inReady does not depend on inValid.
- On accept: buffer <= inData, idx <= 0, cnt <= effective count, state <= EMIT.
- Output fire occurs when outValid && outReady. On fire with !outLast: idx <= idx + 1. On fire with outLast and no same-cycle accept: state <= IDLE. On fire with outLast and a same-cycle accept: load the new word (the accept wins); state stays EMIT.
- outValid = (state == EMIT). outData = buffer[idx*OUT +: OUT]. outIndex = idx. outLast = (idx == cnt-1). All three are driven from registers and have no combinational path from inData.
- While outValid && !outReady: outData, outIndex and outLast hold stable. Fields are never dropped or reordered.
- When FIELDS == 1 the block behaves as a one-deep pipeline register. Every field has outLast = 1 and outIndex = 0.

## Timing
- Reset values: state IDLE, idx 0, cnt 0, buffer 0. Resulting outputs: outValid 0, outData 0, outIndex 0, outLast 0, inReady 1 (from the first cycle after reset deasserts).
- Reset asserted mid-word discards the buffered word and any remaining fields. A handshake presented in a reset cycle is ignored.
- Latency: a word accepted in cycle t presents field 0 in cycle t+1.
- Throughput: with outReady held high, a count-n word occupies exactly n output cycles. Back-to-back words produce a continuous outValid with no idle cycle.
- A word accepted while in IDLE never produces a same-cycle output.

## Test plan
- IN=32, OUT=8. Accept inData=0xDDCCBBAA with inCount=0 and outReady=1. Required: from the next cycle, outData 0xAA, 0xBB, 0xCC, 0xDD; outIndex 0..3; outLast only on 0xDD; inReady high in the 0xDD cycle.
- Same config, two words 0x04030201 (count 2) and 0x08070605 (count 3) presented back-to-back. Required: continuous output 01, 02, 05, 06, 07; outLast on 02 and 07; no idle cycle between words.
- Backpressure: drop outReady for 3 cycles while field 0xBB is presented. Required: outData, outIndex and outLast hold stable; inReady = 0; emission resumes with 0xBB and no field is lost.
- Assert reset while outIndex=1 of a 4-field word. Required: next cycle outValid=0 and inReady=1. The next accepted word starts at outIndex 0.
- Boundary counts: inCount=1 gives a single field with outLast=1. inCount=7 is clamped to 4 fields. With IN=OUT=8, 0x5A passes through with 1-cycle latency and outLast=1.
- Random stimulus on both handshakes. Required: a scoreboard sees every field in order, and the check outData == FieldRead-equivalent (in >> k*OUT)[OUT-1:0] holds for every field.
